fun: RTL and testbench
======================

FUN -- requirements
Module: fun

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; these are the only clock and reset.
REQ-002 clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_i  input  8  unsigned multiplicand operand.
REQ-005 b_i  input  8  unsigned operand whose integer cube root is taken.
REQ-006 start  input  1  single-cycle request; sampled on a rising clk edge.
REQ-007 result  output  11  registered unsigned result, a_i * floor(cbrt(b_i)).
REQ-008 busy  output  1  registered; high while a computation is in progress.

Function
REQ-009 The block SHALL compute result = a * floor(cbrt(b)) exactly, for all a, b in 0..255; the maximum value is 255*6 = 1530, which fits in 11 bits, and no truncation SHALL occur.
REQ-010 FSM states SHALL be IDLE, Y_SHIFT, R_MUL, CALC_B, CMP and A_MUL; reset state is IDLE.
REQ-011 IDLE with start=1 at a clk edge: latch a_i and b_i, clear root y=0, set shift s=6, set busy=1, go to Y_SHIFT.
REQ-012 start is ignored in every state except IDLE, and operand changes after the latch have no effect.
REQ-013 Root algorithm: three iterations, with s = 6, 3, 0, each taking exactly 6 cycles, in this order:
- Y_SHIFT (1 cycle): y <= 2*y.
- R_MUL (3 cycles): y*(y+1) on a shared shift-add multiplier, 1 multiplier bit per cycle, 3-bit multiplier operand.
- CALC_B (1 cycle): t <= (3*prod + 1) << s, with t at least 10 bits wide.
- CMP (1 cycle): if x >= t then x <= x - t and y <= y + 1; then s <= s - 3.
REQ-014 After the CMP of the s=0 iteration, the FSM SHALL go to A_MUL, which computes a*y on the same shift-add multiplier in 3 cycles.
REQ-015 On the last A_MUL edge the block SHALL load result with the product, drive busy=0 and return to IDLE, all on that same edge.
REQ-016 Latency: busy SHALL be high for exactly 21 clock cycles after the accepting edge (3 iterations x 6 cycles, plus 3); the result is valid when busy falls.
REQ-017 result SHALL hold its value from completion until the next completion or reset; it is not cleared when a new start is accepted.
REQ-018 start=1 on the edge where busy falls SHALL be ignored; a new start is accepted from the next edge in IDLE.
REQ-019 With b=0 the root is 0 and result = 0; with a=0, result = 0; latency is unchanged in both cases.
REQ-020 The internal remainder x is 8 bits; because of the compare-before-subtract in CMP, the subtraction never underflows.

Reset
REQ-021 rst=1 SHALL immediately force, asynchronously: state=IDLE, busy=0, result=0, and all internal registers to 0.
REQ-022 Reset asserted during a computation SHALL abort it; no result is produced and result reads 0.
REQ-023 After rst is released, the block SHALL accept start on the first rising edge at which it is sampled high.

Verification
REQ-024 Cube-root sweep, each from reset then start:
- a=5, b=27 -> 15
- a=3, b=64 -> 12
- a=9, b=125 -> 45
- a=11, b=216 -> 66
REQ-025 Non-cube boundaries:
- a=32, b=172 -> 160
- a=44, b=255 -> 264
- a=84, b=84 -> 336
- a=101, b=2 -> 101
- a=255, b=200 -> 1275
REQ-026 Zero case: a=97, b=0 -> result 0; busy high exactly 21 cycles.
REQ-027 Busy protocol:
- busy rises on the edge that samples start.
- busy falls exactly 21 edges later.
- start pulsed mid-computation with a=1, b=1 does not alter the result of a=5, b=27 (15).
REQ-028 Reset mid-operation: assert rst 10 cycles into a=255, b=200 -> busy=0 and result=0 immediately; a subsequent a=3, b=64 -> 12.

Source files
------------

// File: rtl/fun.sv
// Sequential a * floor(cbrt(b)): three 6-cycle digit-by-digit cube-root iterations,
// then a 3-cycle product on the same shift-add multiplier.
module fun (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic        start,
  output logic [10:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    Y_SHIFT = 3'd1,
    R_MUL   = 3'd2,
    CALC_B  = 3'd3,
    CMP     = 3'd4,
    A_MUL   = 3'd5
  } state_t;

  state_t state, state_next;

  logic [7:0]  a_r;
  logic [7:0]  x;
  logic [2:0]  y;
  logic [2:0]  s;
  logic [9:0]  t;
  logic [10:0] mcand;
  logic [2:0]  mplier;
  logic [10:0] prod;
  logic [1:0]  cnt;

  logic        take;
  logic [2:0]  y_dbl;
  logic [2:0]  y_cmp;
  logic [10:0] prod_add;
  logic [15:0] t_wide;

  always_comb begin
    take     = {2'b00, x} >= t;
    y_dbl    = {y[1:0], 1'b0};
    y_cmp    = take ? y + 3'd1 : y;
    prod_add = mplier[0] ? prod + mcand : prod;
    t_wide   = (({5'd0, prod} * 16'd3) + 16'd1) << s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = Y_SHIFT;
      Y_SHIFT: state_next = R_MUL;
      R_MUL:   if (cnt == 2'd2) state_next = CALC_B;
      CALC_B:  state_next = CMP;
      CMP:     state_next = (s == 3'd0) ? A_MUL : Y_SHIFT;
      A_MUL:   if (cnt == 2'd2) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      x      <= '0;
      y      <= '0;
      s      <= '0;
      t      <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a_i;
            x    <= b_i;
            y    <= '0;
            s    <= 3'd6;
            busy <= 1'b1;
          end
        end
        Y_SHIFT: begin
          // Multiplier is preloaded with the doubled root so R_MUL forms y*(y+1).
          y      <= y_dbl;
          mcand  <= {8'd0, y_dbl};
          mplier <= y_dbl + 3'd1;
          prod   <= '0;
          cnt    <= '0;
        end
        R_MUL: begin
          prod   <= prod_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 2'd1;
        end
        CALC_B: t <= t_wide[9:0];
        CMP: begin
          if (take) x <= x - t[7:0];
          y      <= y_cmp;
          if (s != 3'd0) s <= s - 3'd3;
          mcand  <= {3'd0, a_r};
          mplier <= y_cmp;
          prod   <= '0;
          cnt    <= '0;
        end
        A_MUL: begin
          prod   <= prod_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 2'd1;
          if (cnt == 2'd2) begin
            result <= prod_add;
            busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fun.sv
// Directed checks of fun: cube-root products, latency, busy protocol and reset abort.
module tb_fun;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a_i = '0;
  logic [7:0]  b_i = '0;
  logic        start = 1'b0;
  logic [10:0] result;
  logic        busy;

  int total = 0;
  int bad = 0;

  fun dut (
    .clk    (clk),
    .rst    (rst),
    .a_i    (a_i),
    .b_i    (b_i),
    .start  (start),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mid: cycle after acceptance at which a stray start (a=1,b=1) is pulsed, 0 for none.
  // late: also raise start on the edge where busy falls and check it is ignored.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [10:0] exp,
                     input int mid, input bit late);
    int n;
    logic [10:0] r0;
    n = 0;
    @(negedge clk);
    r0 = result;
    a_i = a;
    b_i = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("result_hold", result, r0);
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
      start = (n == mid) || (late && n == 20);
      if (n == mid) begin
        a_i = 8'd1;
        b_i = 8'd1;
      end
    end
    start = 1'b0;
    check("latency", n, 21);
    check("result", result, exp);
    if (late) begin
      @(posedge clk);
      #1;
      check("late_start_ignored", busy, 0);
    end
  endtask

  logic [7:0]  va [10] = '{8'd5, 8'd3, 8'd9, 8'd11, 8'd32, 8'd44, 8'd84, 8'd101, 8'd255, 8'd97};
  logic [7:0]  vb [10] = '{8'd27, 8'd64, 8'd125, 8'd216, 8'd172, 8'd255, 8'd84, 8'd2, 8'd200, 8'd0};
  logic [10:0] ve [10] = '{11'd15, 11'd12, 11'd45, 11'd66, 11'd160, 11'd264, 11'd336, 11'd101,
                           11'd1275, 11'd0};

  initial begin
    #2;
    check("reset_busy", busy, 0);
    check("reset_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run(va[i], vb[i], ve[i], 0, 1'b0);
    end

    // Back-to-back without reset: result holds previous value while busy.
    run(8'd5, 8'd27, 11'd15, 5, 1'b1);
    run(8'd9, 8'd125, 11'd45, 0, 1'b0);

    // Reset mid-operation.
    @(negedge clk);
    a_i = 8'd255;
    b_i = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'd3, 8'd64, 11'd12, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
